// File: rtl/twos_pkg.sv
// Shared definitions for the two's complement / sign-magnitude converters.
package twos_pkg;

   // Default operand width, shared with the twos_compliment encoder.
   localparam int DEFAULT_WIDTH = 8;

   // Converter FSM encoding.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Bits needed to count to value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/twos_to_sign_mag_serial_negate_cell.sv
// One bit of a serial two's complement negation: copy bits up to and
// including the first one, invert every bit after it. Only applied when
// the operand is negative; positive operands pass straight through.
module serial_negate_cell (
   input  logic a_bit,
   input  logic neg,
   input  logic seen_one,
   output logic mbit,
   output logic seen_one_next
);

   assign mbit          = a_bit ^ (neg & seen_one);
   assign seen_one_next = seen_one | a_bit;

endmodule

// File: rtl/twos_to_sign_mag.sv
// Bit-serial two's complement to sign-magnitude decoder. An operand is
// captured in IDLE, its magnitude bits are produced LSB-first over WIDTH-1
// SHIFT cycles, and the result is published with a one-cycle ready strobe.
module twos_to_sign_mag
   import twos_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   output logic             busy,
   output logic             ready,
   output logic             sign,
   output logic             ovf,
   output logic [WIDTH-1:0] Output
);

   localparam int             CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic               neg_q, neg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               seen_q, seen_d;
   logic [WIDTH-2:0]   mag_q, mag_d;
   logic               busy_d, ready_d, sign_d, ovf_d;
   logic [WIDTH-1:0]   out_d;

   logic               a_bit;
   logic               mbit;
   logic               seen_next;
   logic [WIDTH-1:0]   mag_cat;
   logic [WIDTH-2:0]   mag_shifted;

   assign a_bit = a_q[cnt_q];

   serial_negate_cell u_cell (
      .a_bit         (a_bit),
      .neg           (neg_q),
      .seen_one      (seen_q),
      .mbit          (mbit),
      .seen_one_next (seen_next)
   );

   // New bit enters at the top, so after WIDTH-1 shifts bit k sits at mag[k].
   assign mag_cat     = {mbit, mag_q};
   assign mag_shifted = mag_cat[WIDTH-1:1];

   // Next-state and next-register values for the whole datapath.
   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      a_d     = a_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      mag_d   = mag_q;
      busy_d  = busy;
      ready_d = 1'b0;
      sign_d  = sign;
      ovf_d   = ovf;
      out_d   = Output;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_SHIFT;
               a_d     = A;
               neg_d   = A[WIDTH-1];
               cnt_d   = '0;
               seen_d  = 1'b0;
               mag_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_SHIFT: begin
            mag_d  = mag_shifted;
            seen_d = seen_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               cnt_d   = '0;
               out_d   = {neg_q, mag_shifted};
               sign_d  = neg_q;
               // Only the most-negative value has a sign bit and all-zero low bits.
               ovf_d   = neg_q & (a_q[WIDTH-2:0] == '0);
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         mag_q   <= '0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         sign    <= 1'b0;
         ovf     <= 1'b0;
         Output  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         a_q     <= a_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         mag_q   <= mag_d;
         busy    <= busy_d;
         ready   <= ready_d;
         sign    <= sign_d;
         ovf     <= ovf_d;
         Output  <= out_d;
      end
   end

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Scoreboard bench for twos_to_sign_mag: stimulus pushes expected results,
// a negedge monitor pops and compares whenever ready is seen.
module tb_twos_to_sign_mag;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [WIDTH-1:0] A;
   logic             busy;
   logic             ready;
   logic             sign;
   logic             ovf;
   logic [WIDTH-1:0] Output;

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic             sgn;
      logic             ov;
   } result_t;

   result_t exp_q[$];
   int      total_cnt = 0;
   int      pass_cnt  = 0;
   int      ready_cnt = 0;

   twos_to_sign_mag #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .A      (A),
      .busy   (busy),
      .ready  (ready),
      .sign   (sign),
      .ovf    (ovf),
      .Output (Output)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
   endtask

   // Reference decoder: arithmetic negation, independent of the serial rule.
   function automatic result_t model(input logic [WIDTH-1:0] a);
      logic [WIDTH-1:0] m;
      result_t          r;
      m     = a[WIDTH-1] ? (~a + 1'b1) : a;
      r.out = {a[WIDTH-1], m[WIDTH-2:0]};
      r.sgn = a[WIDTH-1];
      r.ov  = (a == {1'b1, {(WIDTH-1){1'b0}}});
      return r;
   endfunction

   // Monitor: every ready strobe must match the oldest expected result.
   always @(negedge clk) begin
      result_t e;
      if (ready === 1'b1) begin
         ready_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", {22'd0, Output, sign, ovf}, {22'd0, e.out, e.sgn, e.ov});
         end
      end
   end

   // One conversion: pulse en, wait (bounded) for ready, check busy length and strobe width.
   task automatic convert(input logic [WIDTH-1:0] a, input result_t exp_r);
      int busy_n;
      bit got;
      exp_q.push_back(exp_r);
      @(negedge clk);
      en = 1'b1;
      A  = a;
      @(negedge clk);
      en = 1'b0;
      busy_n = 0;
      got    = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         if (ready === 1'b1) got = 1'b1;
         else begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
         end
      end
      check("ready_timeout", {31'd0, got}, 32'd1);
      check("busy_cycles", busy_n, WIDTH - 1);
      @(negedge clk);
      check("ready_strobe_width", {31'd0, ready}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int rc;
      bit got;
      rst = 1'b1;
      en  = 1'b0;
      A   = '0;
      repeat (2) @(negedge clk);
      check("reset_busy",   {31'd0, busy},   32'd0);
      check("reset_ready",  {31'd0, ready},  32'd0);
      check("reset_output", {24'd0, Output}, 32'd0);
      check("reset_sign",   {31'd0, sign},   32'd0);
      check("reset_ovf",    {31'd0, ovf},    32'd0);
      rst = 1'b0;

      // Directed vectors with hand-computed results.
      convert(8'h0C, '{out: 8'h0C, sgn: 1'b0, ov: 1'b0});
      convert(8'hF4, '{out: 8'h8C, sgn: 1'b1, ov: 1'b0});
      convert(8'hFF, '{out: 8'h81, sgn: 1'b1, ov: 1'b0});
      convert(8'h80, '{out: 8'h80, sgn: 1'b1, ov: 1'b1});

      // en held high, A changed mid-conversion; second capture WIDTH+1 edges later.
      exp_q.push_back('{out: 8'h05, sgn: 1'b0, ov: 1'b0});
      exp_q.push_back('{out: 8'h85, sgn: 1'b1, ov: 1'b0});
      @(negedge clk);
      en = 1'b1;
      A  = 8'h05;
      for (int n = 1; n <= WIDTH + 2; n++) begin
         @(negedge clk);
         if (n == 1) check("held_first_busy", {31'd0, busy}, 32'd1);
         if (n == 3) A = 8'hFB;
         if (n == 4) check("hold_during_shift", {24'd0, Output}, 32'h80);
         if (n == WIDTH + 1) check("held_gap_idle", {31'd0, busy}, 32'd0);
         if (n == WIDTH + 2) begin
            check("held_recapture", {31'd0, busy}, 32'd1);
            en = 1'b0;
         end
      end
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         if (ready === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      check("held_ready_timeout", {31'd0, got}, 32'd1);
      @(negedge clk);

      // Reset in the middle of a conversion discards it.
      @(negedge clk);
      en = 1'b1;
      A  = 8'hF4;
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_busy",   {31'd0, busy},   32'd0);
      check("async_rst_output", {24'd0, Output}, 32'd0);
      check("async_rst_sign",   {31'd0, sign},   32'd0);
      check("async_rst_ovf",    {31'd0, ovf},    32'd0);
      @(negedge clk);
      rst = 1'b0;
      rc  = ready_cnt;
      repeat (12) @(negedge clk);
      check("no_ready_after_reset", ready_cnt, rc);
      convert(8'h03, '{out: 8'h03, sgn: 1'b0, ov: 1'b0});
      convert(8'h00, '{out: 8'h00, sgn: 1'b0, ov: 1'b0});

      // Exhaustive sweep against the reference model.
      rc = ready_cnt;
      for (int v = 0; v < 256; v++) begin
         convert(8'(v), model(8'(v)));
      end
      check("sweep_ready_count", ready_cnt - rc, 256);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
